// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: operands, Hack control bits and op on the
// request side, result and flags on the response side, each with valid/ready.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx, nx, zy, ny, f, no;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr, ng, cy, ov;

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, op, out_ready,
        input  in_ready, out_valid, out, zr, ng, cy, ov
    );

    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, op, out_ready,
        output in_ready, out_valid, out, zr, ng, cy, ov
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle Hack ALU: single-cycle hack ops, iterative 1-bit/cycle shifts and
// a shift-add unsigned multiplier, one operation in flight at a time.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [1:0] {OP_HACK = 2'b00, OP_SHL = 2'b01, OP_SHR = 2'b10, OP_MUL = 2'b11} op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             no_q, no_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // shift value, or product high half
    logic [WIDTH-1:0] mpl_q, mpl_d;   // multiplier, collects product low half
    logic [WIDTH-1:0] mcd_q, mcd_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d, ng_q, ng_d, cy_q, cy_d, ov_q, ov_d;

    logic [WIDTH-1:0] x2, y2, res, shifted;
    logic [WIDTH:0]   hsum, msum;
    logic             load, fin_no, res_cy, res_ov, shift_out;

    assign x2 = bus.nx ? ~(bus.zx ? '0 : bus.x) : (bus.zx ? '0 : bus.x);
    assign y2 = bus.ny ? ~(bus.zy ? '0 : bus.y) : (bus.zy ? '0 : bus.y);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        no_d    = no_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mpl_d   = mpl_q;
        mcd_d   = mcd_q;
        out_d   = out_q;
        zr_d    = zr_q;
        ng_d    = ng_q;
        cy_d    = cy_q;
        ov_d    = ov_q;
        load    = 1'b0;
        fin_no  = no_q;
        res     = '0;
        res_cy  = 1'b0;
        res_ov  = 1'b0;

        hsum = {1'b0, x2} + {1'b0, y2};
        msum = {1'b0, acc_q} + {1'b0, (mpl_q[0] ? mcd_q : '0)};
        if (op_q == OP_SHL) begin
            shifted   = {acc_q[WIDTH-2:0], 1'b0};
            shift_out = acc_q[WIDTH-1];
        end else begin
            shifted   = {1'b0, acc_q[WIDTH-1:1]};
            shift_out = acc_q[0];
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d   = op_e'(bus.op);
                    no_d   = bus.no;
                    fin_no = bus.no;
                    case (op_e'(bus.op))
                        OP_HACK: begin
                            load    = 1'b1;
                            res     = bus.f ? hsum[WIDTH-1:0] : (x2 & y2);
                            res_cy  = bus.f & hsum[WIDTH];
                            res_ov  = bus.f & (x2[WIDTH-1] == y2[WIDTH-1]) & (hsum[WIDTH-1] != x2[WIDTH-1]);
                            state_d = DONE;
                        end
                        OP_SHL, OP_SHR: begin
                            if (y2[SHW-1:0] == '0) begin
                                load    = 1'b1;
                                res     = x2;
                                state_d = DONE;
                            end else begin
                                acc_d   = x2;
                                cnt_d   = CW'(y2[SHW-1:0]);
                                state_d = BUSY;
                            end
                        end
                        default: begin
                            acc_d   = '0;
                            mpl_d   = y2;
                            mcd_d   = x2;
                            cnt_d   = CW'(WIDTH);
                            state_d = BUSY;
                        end
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    acc_d  = msum[WIDTH:1];
                    mpl_d  = {msum[0], mpl_q[WIDTH-1:1]};
                    res    = mpl_d;
                    res_cy = |acc_d;
                end else begin
                    acc_d  = shifted;
                    res    = shifted;
                    res_cy = shift_out;
                end
                if (cnt_q == CW'(1)) begin
                    load    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            out_d = fin_no ? ~res : res;
            zr_d  = (out_d == '0);
            ng_d  = out_d[WIDTH-1];
            cy_d  = res_cy;
            ov_d  = res_ov;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_HACK;
            no_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mpl_q   <= '0;
            mcd_q   <= '0;
            out_q   <= '0;
            zr_q    <= 1'b0;
            ng_q    <= 1'b0;
            cy_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            no_q    <= no_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mpl_q   <= mpl_d;
            mcd_q   <= mcd_d;
            out_q   <= out_d;
            zr_q    <= zr_d;
            ng_q    <= ng_d;
            cy_q    <= cy_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;
    assign bus.cy        = cy_q;
    assign bus.ov        = ov_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): a behavioural model pushes expected
// results and latencies to a scoreboard that is popped when out_valid appears.
module tb_alu_seq;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] out;
        logic         zr, ng, cy, ov;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [5:0] ctrl, input logic [1:0] op);
        exp_t           e;
        logic [W-1:0]   x2, y2, r;
        logic [W:0]     s;
        logic [2*W-1:0] t;
        int             cnt;
        x2 = ctrl[5] ? '0 : x;
        if (ctrl[4]) x2 = ~x2;
        y2 = ctrl[3] ? '0 : y;
        if (ctrl[2]) y2 = ~y2;
        cnt  = int'(y2[3:0]);
        e.cy = 1'b0;
        e.ov = 1'b0;
        case (op)
            2'b00: begin
                s     = {1'b0, x2} + {1'b0, y2};
                r     = ctrl[1] ? s[W-1:0] : (x2 & y2);
                e.cy  = ctrl[1] & s[W];
                e.ov  = ctrl[1] & (x2[W-1] == y2[W-1]) & (s[W-1] != x2[W-1]);
                e.lat = 1;
            end
            2'b01: begin
                t     = {{W{1'b0}}, x2} << cnt;
                r     = t[W-1:0];
                e.cy  = t[W];
                e.lat = cnt + 1;
            end
            2'b10: begin
                t     = {x2, {W{1'b0}}} >> cnt;
                r     = t[2*W-1:W];
                e.cy  = t[W-1];
                e.lat = cnt + 1;
            end
            default: begin
                t     = {{W{1'b0}}, x2} * {{W{1'b0}}, y2};
                r     = t[W-1:0];
                e.cy  = |t[2*W-1:W];
                e.lat = W + 1;
            end
        endcase
        e.out = ctrl[0] ? ~r : r;
        e.zr  = (e.out == '0);
        e.ng  = e.out[W-1];
        return e;
    endfunction

    task automatic send(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [5:0] ctrl, input logic [1:0] op);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_before_accept: got %b expected 1", name, bus.in_ready);
        end
        bus.x        = x;
        bus.y        = y;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ctrl;
        bus.op       = op;
        bus.in_valid = 1'b1;
        sb.push_back(model(x, y, ctrl, op));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; counts edges until out_valid.
    task automatic wait_result(input string name, output int n);
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: out_valid never rose within %0d edges", name, n);
        end
    endtask

    task automatic receive(input string name);
        exp_t e;
        int   n;
        wait_result(name, n);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty: got 0 entries expected 1", name);
            return;
        end
        e = sb.pop_front();
        checks += 7;
        if (n !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, n, e.lat);
        end
        if (bus.out !== e.out) begin
            errors++;
            $display("FAIL %s out: got %h expected %h", name, bus.out, e.out);
        end
        if (bus.zr !== e.zr) begin
            errors++;
            $display("FAIL %s zr: got %b expected %b", name, bus.zr, e.zr);
        end
        if (bus.ng !== e.ng) begin
            errors++;
            $display("FAIL %s ng: got %b expected %b", name, bus.ng, e.ng);
        end
        if (bus.cy !== e.cy) begin
            errors++;
            $display("FAIL %s cy: got %b expected %b", name, bus.cy, e.cy);
        end
        if (bus.ov !== e.ov) begin
            errors++;
            $display("FAIL %s ov: got %b expected %b", name, bus.ov, e.ov);
        end
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_in_done: got %b expected 0", name, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s out_valid_after_hs: got %b expected 0", name, bus.out_valid);
        end
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_after_hs: got %b expected 1", name, bus.in_ready);
        end
        if (bus.out !== e.out) begin
            errors++;
            $display("FAIL %s out_kept_after_hs: got %h expected %h", name, bus.out, e.out);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [5:0] ctrl, input logic [1:0] op);
        send(name, x, y, ctrl, op);
        receive(name);
    endtask

    task automatic test_reset();
        #1;
        checks += 3;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset in_ready: got %b expected 1", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset out_valid: got %b expected 0", bus.out_valid);
        end
        if ({bus.out, bus.zr, bus.ng, bus.cy, bus.ov} !== {{W{1'b0}}, 4'b0000}) begin
            errors++;
            $display("FAIL reset outputs: got %h/%b%b%b%b expected 0/0000",
                     bus.out, bus.zr, bus.ng, bus.cy, bus.ov);
        end
    endtask

    task automatic test_hack();
        run_op("add_5_3",      16'd5,    16'd3,    6'b000010, 2'b00);
        run_op("add_ovf",      16'h7FFF, 16'h0001, 6'b000010, 2'b00);
        run_op("add_carry",    16'hFFFF, 16'h0001, 6'b000010, 2'b00);
        run_op("sub_3_5",      16'd3,    16'd5,    6'b010011, 2'b00);
        run_op("const0",       16'h1234, 16'h5678, 6'b101010, 2'b00);
        run_op("and_no",       16'hF0F0, 16'h3C3C, 6'b000001, 2'b00);
    endtask

    task automatic test_shift();
        run_op("shl_1_by4",    16'h0001, 16'd4,    6'b000000, 2'b01);
        run_op("shl_by0",      16'hA5C3, 16'd0,    6'b000000, 2'b01);
        run_op("shr_8001",     16'h8001, 16'd1,    6'b000000, 2'b10);
        run_op("shl_upper_ig", 16'h1234, 16'h0013, 6'b000000, 2'b01);
        run_op("shr_by15_no",  16'hC000, 16'd15,   6'b000001, 2'b10);
    endtask

    task automatic test_multiply();
        run_op("mul_300",      16'd300,  16'd300,  6'b000000, 2'b11);
        run_op("mul_zero",     16'd0,    16'hFFFF, 6'b000000, 2'b11);
        run_op("mul_nx",       16'h0002, 16'd7,    6'b010000, 2'b11);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            run_op("random", 16'($urandom), 16'($urandom), 6'($urandom), op);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n;
        send("bp", 16'h1111, 16'h2222, 6'b000010, 2'b00);
        wait_result("bp", n);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.x        = 16'($urandom);
            bus.op       = 2'b00;
            @(posedge clk);
            #1;
            checks += 3;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold handshake: got valid=%b ready=%b expected valid=1 ready=0",
                         bus.out_valid, bus.in_ready);
            end
            if (bus.out !== e.out) begin
                errors++;
                $display("FAIL bp_hold out: got %h expected %h", bus.out, e.out);
            end
            if ({bus.zr, bus.ng, bus.cy, bus.ov} !== {e.zr, e.ng, e.cy, e.ov}) begin
                errors++;
                $display("FAIL bp_hold flags: got %b%b%b%b expected %b%b%b%b",
                         bus.zr, bus.ng, bus.cy, bus.ov, e.zr, e.ng, e.cy, e.ov);
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ignored_request: got valid=%b ready=%b expected valid=0 ready=1",
                     bus.out_valid, bus.in_ready);
        end
        if (bus.out !== e.out) begin
            errors++;
            $display("FAIL bp_out_kept: got %h expected %h", bus.out, e.out);
        end
    endtask

    task automatic test_reset_mid_op();
        send("rst_mul", 16'd300, 16'd300, 6'b000000, 2'b11);
        sb.delete();
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid out_valid: got %b expected 0", bus.out_valid);
        end
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid in_ready: got %b expected 1", bus.in_ready);
        end
        if (bus.out !== '0) begin
            errors++;
            $display("FAIL rst_mid out: got %h expected 0000", bus.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid discarded: got out_valid %b expected 0", bus.out_valid);
        end
        run_op("after_rst_2p2", 16'd2, 16'd2, 6'b000010, 2'b00);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'b0;
        bus.op        = 2'b00;
        test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_hack();
        test_shift();
        test_multiply();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
